// File: rtl/xgmii_link_pkg.sv
// Shared types and widths for the XGMII link manager.
// The LINK_MGR_STATS_EN build macro (used by xgmii_link_chan) enables per-channel drop counters.
package xgmii_link_pkg;

    localparam int RETRY_W = 4;
    localparam int DROP_W  = 8;

    typedef enum logic [2:0] {
        ST_DISABLED,
        ST_RESET,
        ST_WAIT_DONE,
        ST_WAIT_LOCK,
        ST_UP,
        ST_FAIL
    } chan_state_e;

endpackage

// File: rtl/xgmii_link_chan.sv
// Single-channel bring-up FSM: reset pulse, qualify, supervise, retry with timeout.
// Define LINK_MGR_STATS_EN to build the saturating UP->RESET drop counter.
module xgmii_link_chan
    import xgmii_link_pkg::*;
#(
    parameter int P_RST_PULSE   = 64,
    parameter int P_UP_CYCLES   = 1024,
    parameter int P_DOWN_CYCLES = 16,
    parameter int P_TIMEOUT     = 1048576,
    parameter int P_RETRY_MAX   = 8
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_en,
    input  logic               i_rst_done,
    input  logic               i_block_sync,
    input  logic               i_pcs_rx_link,
    input  logic               i_clr_fail,
    output logic               o_chan_rst,
    output logic               o_link_up,
    output logic               o_fail,
    output logic [RETRY_W-1:0] o_retry_cnt,
    output logic [DROP_W-1:0]  o_drop_cnt
);

    localparam int RST_W = $clog2(P_RST_PULSE) + 1;
    localparam int TMO_W = $clog2(P_TIMEOUT) + 1;
    localparam int UP_W  = $clog2(P_UP_CYCLES) + 1;
    localparam int DN_W  = $clog2(P_DOWN_CYCLES) + 1;

    localparam logic [RST_W-1:0]   RST_LAST  = RST_W'(P_RST_PULSE - 1);
    localparam logic [TMO_W-1:0]   TMO_LAST  = TMO_W'(P_TIMEOUT - 1);
    localparam logic [UP_W-1:0]    UP_LAST   = UP_W'(P_UP_CYCLES - 1);
    localparam logic [DN_W-1:0]    DN_LAST   = DN_W'(P_DOWN_CYCLES - 1);
    localparam logic [RETRY_W-1:0] RETRY_LIM = RETRY_W'(P_RETRY_MAX);

    chan_state_e        state_q, state_d;
    logic [RST_W-1:0]   rst_cnt_q, rst_cnt_d;
    logic [TMO_W-1:0]   tmo_cnt_q, tmo_cnt_d;
    logic [UP_W-1:0]    up_cnt_q, up_cnt_d;
    logic [DN_W-1:0]    dn_cnt_q, dn_cnt_d;
    logic [RETRY_W-1:0] retry_q, retry_d, retry_inc;
    logic               chan_rst_q, chan_rst_d;
    logic               link_up_q, link_up_d;
    logic               fail_q, fail_d;
    logic               good;

    assign good      = i_rst_done & i_block_sync & i_pcs_rx_link;
    assign retry_inc = retry_q + 1'b1;

    // NOTE: every always_comb target gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        state_d   = state_q;
        rst_cnt_d = rst_cnt_q;
        tmo_cnt_d = tmo_cnt_q;
        up_cnt_d  = up_cnt_q;
        dn_cnt_d  = dn_cnt_q;
        retry_d   = retry_q;

        if (!i_en) begin
            state_d   = ST_DISABLED;
            rst_cnt_d = '0;
            tmo_cnt_d = '0;
            up_cnt_d  = '0;
            dn_cnt_d  = '0;
            retry_d   = '0;
        end else begin
            unique case (state_q)
                ST_DISABLED: begin
                    state_d   = ST_RESET;
                    rst_cnt_d = '0;
                end
                ST_RESET: begin
                    if (rst_cnt_q == RST_LAST) begin
                        state_d   = ST_WAIT_DONE;
                        tmo_cnt_d = '0;
                        up_cnt_d  = '0;
                    end else begin
                        rst_cnt_d = rst_cnt_q + 1'b1;
                    end
                end
                ST_WAIT_DONE, ST_WAIT_LOCK: begin
                    if (state_q == ST_WAIT_DONE && i_rst_done) state_d = ST_WAIT_LOCK;
                    if (state_q == ST_WAIT_LOCK) up_cnt_d = good ? up_cnt_q + 1'b1 : '0;
                    // Qualification completing on the timeout cycle takes priority.
                    if (state_q == ST_WAIT_LOCK && good && up_cnt_q == UP_LAST) begin
                        state_d  = ST_UP;
                        retry_d  = '0;
                        up_cnt_d = '0;
                        dn_cnt_d = '0;
                    end else if (tmo_cnt_q == TMO_LAST) begin
                        retry_d   = retry_inc;
                        rst_cnt_d = '0;
                        state_d   = (retry_inc == RETRY_LIM) ? ST_FAIL : ST_RESET;
                    end else begin
                        tmo_cnt_d = tmo_cnt_q + 1'b1;
                    end
                end
                ST_UP: begin
                    if (good) begin
                        dn_cnt_d = '0;
                    end else if (dn_cnt_q == DN_LAST) begin
                        state_d   = ST_RESET;
                        rst_cnt_d = '0;
                        dn_cnt_d  = '0;
                    end else begin
                        dn_cnt_d = dn_cnt_q + 1'b1;
                    end
                end
                ST_FAIL: begin
                    if (i_clr_fail) begin
                        state_d   = ST_RESET;
                        retry_d   = '0;
                        rst_cnt_d = '0;
                    end
                end
                default: state_d = ST_DISABLED;
            endcase
        end
    end

    // Outputs are decoded from the next state so they flip on the same edge as the state.
    always_comb begin
        chan_rst_d = (state_d == ST_DISABLED) || (state_d == ST_RESET) || (state_d == ST_FAIL);
        link_up_d  = (state_d == ST_UP);
        fail_d     = (state_d == ST_FAIL);
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state_q    <= ST_DISABLED;
            rst_cnt_q  <= '0;
            tmo_cnt_q  <= '0;
            up_cnt_q   <= '0;
            dn_cnt_q   <= '0;
            retry_q    <= '0;
            chan_rst_q <= 1'b1;
            link_up_q  <= 1'b0;
            fail_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            rst_cnt_q  <= rst_cnt_d;
            tmo_cnt_q  <= tmo_cnt_d;
            up_cnt_q   <= up_cnt_d;
            dn_cnt_q   <= dn_cnt_d;
            retry_q    <= retry_d;
            chan_rst_q <= chan_rst_d;
            link_up_q  <= link_up_d;
            fail_q     <= fail_d;
        end
    end

    assign o_chan_rst  = chan_rst_q;
    assign o_link_up   = link_up_q;
    assign o_fail      = fail_q;
    assign o_retry_cnt = retry_q;

`ifdef LINK_MGR_STATS_EN
    logic              drop_evt;
    logic [DROP_W-1:0] drop_cnt_q, drop_cnt_d;

    // Leaving UP for RESET only happens through the down counter, i.e. a link drop.
    assign drop_evt = (state_q == ST_UP) && (state_d == ST_RESET);

    always_comb begin
        drop_cnt_d = drop_cnt_q;
        if (drop_evt && drop_cnt_q != '1) drop_cnt_d = drop_cnt_q + 1'b1;
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) drop_cnt_q <= '0;
        else        drop_cnt_q <= drop_cnt_d;
    end

    assign o_drop_cnt = drop_cnt_q;
`else
    assign o_drop_cnt = '0;
`endif

endmodule

// File: rtl/xgmii_link_mgr.sv
// Multi-channel 10GBASE-R link supervisor: one xgmii_link_chan per channel plus all-up summary.
// Build macro LINK_MGR_STATS_EN enables the per-channel link-drop counters on o_drop_cnt.
module xgmii_link_mgr
    import xgmii_link_pkg::*;
#(
    parameter int P_CHANNELS    = 4,
    parameter int P_RST_PULSE   = 64,
    parameter int P_UP_CYCLES   = 1024,
    parameter int P_DOWN_CYCLES = 16,
    parameter int P_TIMEOUT     = 1048576,
    parameter int P_RETRY_MAX   = 8
) (
    input  logic                          i_clk,
    input  logic                          i_rst,
    input  logic [P_CHANNELS-1:0]         i_chan_en,
    input  logic [P_CHANNELS-1:0]         i_rst_done,
    input  logic [P_CHANNELS-1:0]         i_block_sync,
    input  logic [P_CHANNELS-1:0]         i_pcs_rx_link,
    input  logic [P_CHANNELS-1:0]         i_clr_fail,
    output logic [P_CHANNELS-1:0]         o_chan_rst,
    output logic [P_CHANNELS-1:0]         o_link_up,
    output logic                          o_all_up,
    output logic [P_CHANNELS-1:0]         o_fail,
    output logic [RETRY_W*P_CHANNELS-1:0] o_retry_cnt,
    output logic [DROP_W*P_CHANNELS-1:0]  o_drop_cnt
);

    logic all_up_q, all_up_d;

    for (genvar k = 0; k < P_CHANNELS; k++) begin : g_chan
        xgmii_link_chan #(
            .P_RST_PULSE  (P_RST_PULSE),
            .P_UP_CYCLES  (P_UP_CYCLES),
            .P_DOWN_CYCLES(P_DOWN_CYCLES),
            .P_TIMEOUT    (P_TIMEOUT),
            .P_RETRY_MAX  (P_RETRY_MAX)
        ) u_chan (
            .i_clk        (i_clk),
            .i_rst        (i_rst),
            .i_en         (i_chan_en[k]),
            .i_rst_done   (i_rst_done[k]),
            .i_block_sync (i_block_sync[k]),
            .i_pcs_rx_link(i_pcs_rx_link[k]),
            .i_clr_fail   (i_clr_fail[k]),
            .o_chan_rst   (o_chan_rst[k]),
            .o_link_up    (o_link_up[k]),
            .o_fail       (o_fail[k]),
            .o_retry_cnt  (o_retry_cnt[RETRY_W*k +: RETRY_W]),
            .o_drop_cnt   (o_drop_cnt[DROP_W*k +: DROP_W])
        );
    end

    // Disabled channels are masked out; with nothing enabled the summary stays low.
    always_comb begin
        all_up_d = (|i_chan_en) && (&(o_link_up | ~i_chan_en));
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) all_up_q <= 1'b0;
        else        all_up_q <= all_up_d;
    end

    assign o_all_up = all_up_q;

endmodule

// File: tb/tb_xgmii_link_mgr.sv
// Directed scoreboard bench for xgmii_link_mgr (2 channels, shortened timing parameters).
module tb_xgmii_link_mgr;

    localparam int NCH = 2;
`ifdef LINK_MGR_STATS_EN
    localparam int STATS = 1;
`else
    localparam int STATS = 0;
`endif

    logic           clk = 1'b0;
    logic           rst_n;
    logic [NCH-1:0] chan_en, rst_done, block_sync, pcs_rx_link, clr_fail;
    logic [NCH-1:0] chan_rst, link_up, fail;
    logic           all_up;
    logic [4*NCH-1:0] retry_cnt;
    logic [8*NCH-1:0] drop_cnt;

    int n_checks = 0;
    int n_errors = 0;

    string       tag_q[$];
    logic [31:0] exp_q[$];

    always #5 clk = ~clk;

    xgmii_link_mgr #(
        .P_CHANNELS   (NCH),
        .P_RST_PULSE  (4),
        .P_UP_CYCLES  (8),
        .P_DOWN_CYCLES(3),
        .P_TIMEOUT    (50),
        .P_RETRY_MAX  (3)
    ) dut (
        .i_clk        (clk),
        .i_rst        (rst_n),
        .i_chan_en    (chan_en),
        .i_rst_done   (rst_done),
        .i_block_sync (block_sync),
        .i_pcs_rx_link(pcs_rx_link),
        .i_clr_fail   (clr_fail),
        .o_chan_rst   (chan_rst),
        .o_link_up    (link_up),
        .o_all_up     (all_up),
        .o_fail       (fail),
        .o_retry_cnt  (retry_cnt),
        .o_drop_cnt   (drop_cnt)
    );

    task automatic expect_val(input string tag, input logic [31:0] v);
        tag_q.push_back(tag);
        exp_q.push_back(v);
    endtask

    task automatic check(input logic [31:0] obs);
        string       t;
        logic [31:0] e;
        n_checks++;
        if (exp_q.size() == 0) begin
            n_errors++;
            $error("FAIL scoreboard_empty: observed=%0h expected=none", obs);
            return;
        end
        t = tag_q.pop_front();
        e = exp_q.pop_front();
        assert (obs === e) else begin
            n_errors++;
            $error("FAIL %s: observed=%0h expected=%0h", t, obs, e);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0; chan_en = '0; rst_done = '0; block_sync = '0; pcs_rx_link = '0; clr_fail = '0;
        #12;
        expect_val("rst_chan_rst", 32'h3);   check(32'(chan_rst));
        expect_val("rst_link_up", 32'h0);    check(32'(link_up));
        expect_val("rst_all_up", 32'h0);     check(32'(all_up));
        expect_val("rst_fail", 32'h0);       check(32'(fail));
        expect_val("rst_retry", 32'h0);      check(32'(retry_cnt));
        expect_val("rst_drop", 32'h0);       check(32'(drop_cnt));
        rst_n = 1'b1;
        tick(2);
        expect_val("all_up_none_enabled", 32'h0); check(32'(all_up));

        // Bring-up of channel 0: 4-cycle reset pulse, then 8 good cycles in WAIT_LOCK.
        chan_en[0] = 1'b1;
        tick(4);
        expect_val("rst_pulse_hi", 32'h1);   check(32'(chan_rst[0]));
        tick(1);
        expect_val("rst_pulse_end", 32'h0);  check(32'(chan_rst[0]));
        tick(2);
        rst_done[0] = 1'b1;
        tick(1);
        block_sync[0] = 1'b1; pcs_rx_link[0] = 1'b1;
        tick(7);
        expect_val("up_early", 32'h0);       check(32'(link_up[0]));
        tick(1);
        expect_val("up_exact", 32'h1);       check(32'(link_up));
        expect_val("all_up_lag", 32'h0);     check(32'(all_up));
        expect_val("chan_rst_up", 32'h2);    check(32'(chan_rst));
        tick(1);
        expect_val("all_up_set", 32'h1);     check(32'(all_up));

        clr_fail[0] = 1'b1;
        tick(1);
        clr_fail[0] = 1'b0;
        expect_val("clr_fail_ignored", 32'h1); check(32'(link_up[0]));

        // Two-cycle glitch is absorbed; three cycles forces a re-reset.
        pcs_rx_link[0] = 1'b0;
        tick(2);
        pcs_rx_link[0] = 1'b1;
        tick(1);
        expect_val("glitch_2", 32'h1);       check(32'(link_up[0]));
        pcs_rx_link[0] = 1'b0; block_sync[0] = 1'b0;
        tick(2);
        expect_val("drop_2_up", 32'h1);      check(32'(link_up[0]));
        tick(1);
        pcs_rx_link[0] = 1'b1;
        expect_val("drop_3", 32'h0);         check(32'(link_up[0]));
        expect_val("drop_3_rst", 32'h1);     check(32'(chan_rst[0]));
        expect_val("drop_cnt_1", 32'(STATS)); check(32'(drop_cnt[7:0]));
        expect_val("drop_retry", 32'h0);     check(32'(retry_cnt[3:0]));
        tick(1);
        expect_val("all_up_drop", 32'h0);    check(32'(all_up));

        // No block lock: three 50-cycle timeouts end in FAIL.
        tick(52);
        expect_val("tmo1_before", 32'h0);    check(32'(retry_cnt[3:0]));
        tick(1);
        expect_val("tmo1", 32'h1);           check(32'(retry_cnt[3:0]));
        expect_val("tmo1_rst", 32'h1);       check(32'(chan_rst[0]));
        tick(53);
        expect_val("tmo2_before", 32'h1);    check(32'(retry_cnt[3:0]));
        tick(1);
        expect_val("tmo2", 32'h2);           check(32'(retry_cnt[3:0]));
        tick(53);
        expect_val("fail_early", 32'h0);     check(32'(fail[0]));
        tick(1);
        expect_val("tmo3", 32'h3);           check(32'(retry_cnt[3:0]));
        expect_val("fail_set", 32'h1);       check(32'(fail));
        expect_val("fail_rst", 32'h1);       check(32'(chan_rst[0]));
        tick(5);
        expect_val("fail_hold", 32'h1);      check(32'(fail[0]));
        clr_fail[0] = 1'b1;
        tick(1);
        clr_fail[0] = 1'b0;
        expect_val("clr_retry", 32'h0);      check(32'(retry_cnt[3:0]));
        expect_val("clr_fail", 32'h0);       check(32'(fail[0]));
        expect_val("clr_rst", 32'h1);        check(32'(chan_rst[0]));

        // Qualification completes on the same edge as the timeout: UP wins.
        tick(46);
        block_sync[0] = 1'b1;
        tick(7);
        expect_val("pre_tmo_up", 32'h0);     check(32'(link_up[0]));
        tick(1);
        expect_val("up_on_tmo", 32'h1);      check(32'(link_up[0]));
        expect_val("retry_on_tmo", 32'h0);   check(32'(retry_cnt[3:0]));
        expect_val("rst_on_tmo", 32'h0);     check(32'(chan_rst[0]));

        // Drop again, time out once, then disable in the middle of WAIT_LOCK.
        pcs_rx_link[0] = 1'b0; block_sync[0] = 1'b0;
        tick(3);
        pcs_rx_link[0] = 1'b1;
        expect_val("drop_cnt_2", 32'(2 * STATS)); check(32'(drop_cnt[7:0]));
        tick(54);
        expect_val("tmo_again", 32'h1);      check(32'(retry_cnt[3:0]));
        tick(8);
        expect_val("pre_dis_rst", 32'h0);    check(32'(chan_rst[0]));
        chan_en[0] = 1'b0;
        tick(1);
        expect_val("dis_rst", 32'h1);        check(32'(chan_rst[0]));
        expect_val("dis_retry", 32'h0);      check(32'(retry_cnt[3:0]));
        expect_val("dis_fail", 32'h0);       check(32'(fail[0]));
        expect_val("drop_retained", 32'(2 * STATS)); check(32'(drop_cnt[7:0]));
        tick(1);
        expect_val("all_up_none", 32'h0);    check(32'(all_up));

        // Both channels up together, then asynchronous reset mid-UP.
        rst_done = 2'b11; block_sync = 2'b11; pcs_rx_link = 2'b11; chan_en = 2'b11;
        tick(13);
        expect_val("dual_up_early", 32'h0);  check(32'(link_up));
        tick(1);
        expect_val("dual_up", 32'h3);        check(32'(link_up));
        tick(1);
        expect_val("dual_all_up", 32'h1);    check(32'(all_up));
        expect_val("dual_drop", 32'(2 * STATS)); check(32'(drop_cnt));
        #2;
        rst_n = 1'b0;
        #1;
        expect_val("arst_chan_rst", 32'h3);  check(32'(chan_rst));
        expect_val("arst_link_up", 32'h0);   check(32'(link_up));
        expect_val("arst_all_up", 32'h0);    check(32'(all_up));
        expect_val("arst_fail", 32'h0);      check(32'(fail));
        expect_val("arst_retry", 32'h0);     check(32'(retry_cnt));
        expect_val("arst_drop", 32'h0);      check(32'(drop_cnt));
        rst_n = 1'b1;
        tick(1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/xgmii_link_mgr.md
# xgmii_link_mgr

Per-channel link bring-up and supervision for P_CHANNELS 10GBASE-R PCS/PMA instances sharing one XGMII core clock. Each channel runs its own reset/qualify/monitor state machine: it pulses the channel's PCS/PMA reset, waits for reset-done and a debounced block lock plus PCS receive link, declares link-up, and retries with a timeout and a bounded retry count. Sits between the multi-channel PCS/PMA wrapper status outputs and the MAC/system control logic.

## Interface
Parameters:
- P_CHANNELS, 4, number of supervised channels (1..16)
- P_RST_PULSE, 64, cycles o_chan_rst is held per reset attempt (>=2)
- P_UP_CYCLES, 1024, consecutive qualified cycles required for link-up
- P_DOWN_CYCLES, 16, consecutive unqualified cycles in UP that force re-reset
- P_TIMEOUT, 1048576, cycles allowed in WAIT_DONE+WAIT_LOCK per attempt
- P_RETRY_MAX, 8, failed attempts before FAIL (1..15)

Ports:
- i_clk  in  1  XGMII core clock; all inputs synchronous to it
- i_rst  in  1  asynchronous, active-low reset
- i_chan_en  in  P_CHANNELS  per-channel enable (level)
- i_rst_done  in  P_CHANNELS  GT tx_resetdone & rx_resetdone
- i_block_sync  in  P_CHANNELS  PCS block lock
- i_pcs_rx_link  in  P_CHANNELS  PCS receive link status
- i_clr_fail  in  P_CHANNELS  single-cycle pulse, releases FAIL
- o_chan_rst  out  P_CHANNELS  per-channel PCS/PMA reset, active-high
- o_link_up  out  P_CHANNELS  channel in UP
- o_all_up  out  1  all enabled channels up
- o_fail  out  P_CHANNELS  retries exhausted
- o_retry_cnt  out  4*P_CHANNELS  current attempt failures per channel, channel k at [4k+3:4k]
- o_drop_cnt  out  8*P_CHANNELS  link-drop count per channel (see Configuration)

## Operation
- Qualified ("good") = i_rst_done & i_block_sync & i_pcs_rx_link for that channel.
- States per channel: DISABLED, RESET, WAIT_DONE, WAIT_LOCK, UP, FAIL.
- DISABLED: o_chan_rst=1. i_chan_en=1 -> RESET.
- RESET: o_chan_rst=1 for exactly P_RST_PULSE cycles, then -> WAIT_DONE; timeout counter cleared.
- WAIT_DONE: o_chan_rst=0; i_rst_done=1 -> WAIT_LOCK.
- WAIT_LOCK: up counter counts consecutive good cycles, clears on any non-good cycle; reaching P_UP_CYCLES -> UP; retry count cleared on entry to UP.
- Timeout counter runs across WAIT_DONE and WAIT_LOCK; reaching P_TIMEOUT without entering UP -> retry count +1; if new count == P_RETRY_MAX -> FAIL else -> RESET.
- UP: o_link_up=1. Down counter counts consecutive non-good cycles; reaching P_DOWN_CYCLES -> RESET (retry count not incremented, drop counter +1). Shorter glitches ignored.
- FAIL: o_fail=1, o_chan_rst=1. i_clr_fail pulse -> RESET with retry count 0.
- i_chan_en=0 in any state -> DISABLED next cycle; retry count, counters, o_fail cleared; drop counter retained.
- o_all_up = AND of o_link_up over channels with i_chan_en=1; 0 when no channel enabled.

## Timing
- Reset values: o_chan_rst all 1, o_link_up 0, o_all_up 0, o_fail 0, o_retry_cnt 0, o_drop_cnt 0; all states DISABLED.
- All outputs registered; o_chan_rst/o_link_up/o_fail change in the same cycle the state register changes.
- i_chan_en rising sampled at edge t -> state RESET from t+1; o_chan_rst low from t+1+P_RST_PULSE.
- Good held from WAIT_LOCK entry -> UP exactly P_UP_CYCLES cycles later.
- o_all_up lags o_link_up by one cycle.
- Simultaneous: UP qualification and timeout in same cycle -> UP wins. i_chan_en=0 overrides everything. i_clr_fail outside FAIL ignored.
- Counters saturate: drop counter at 255; timeout/up/down counters sized $clog2 of their parameter +1.

## Configuration
- LINK_MGR_STATS_EN defined: o_drop_cnt counts UP->RESET link drops per channel, saturating at 255, cleared only by i_rst.
- Not defined: drop counters not synthesised; o_drop_cnt driven constant 0.

## Structure
- Shared package xgmii_link_pkg: channel state enum, retry-count width (4), drop-count width (8).
- One sub-module xgmii_link_chan: single-channel FSM and counters; top generates P_CHANNELS instances and the o_all_up reduction register.

## Test plan
- Bench uses P_RST_PULSE=4, P_UP_CYCLES=8, P_DOWN_CYCLES=3, P_TIMEOUT=50, P_RETRY_MAX=3.
- Enable ch0, rst_done at cycle 10, sync+link from 12 -> o_chan_rst high 4 cycles, o_link_up at exactly 8 good cycles after WAIT_LOCK entry, o_all_up one cycle later.
- Never assert block_sync -> three 50-cycle timeouts, retry_cnt 1,2,3, o_fail=1 after third; i_clr_fail -> RESET, retry_cnt 0.
- In UP drop link 2 cycles -> stays UP; drop 3 cycles -> RESET, drop_cnt=1 (with LINK_MGR_STATS_EN), 0 without.
- Good completes on the timeout cycle -> UP, retry_cnt unchanged.
- Deassert i_chan_en mid-WAIT_LOCK and assert i_rst low mid-UP -> DISABLED next cycle / all outputs to reset values immediately.
